ws2812_rx: RTL

WS2812 single-wire receiver/decoder: samples an incoming WS2812 data line, classifies each high pulse as a 0 or 1 bit, assembles 24-bit GRB pixels, and detects the ≥50 µs low reset code that ends a frame. It is the receive-side counterpart of the LED transmit chain. It is used for loopback self-test of the transmit chain and for capturing frames from an upstream controller into the 64-entry layer RAM. Pixels are delivered MSB-first-assembled with a 6-bit pixel index matching the RAM address width.

---
 rtl/ws2812_pkg.sv | 28 ++
 rtl/edge2en.sv | 20 ++
 rtl/ws2812_rx_sync.sv | 26 ++
 rtl/ws2812_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: definitions shared by the WS2812 transmit and receive sides.
// It holds the receiver state encoding, the default line timing in clk cycles
// at 200 MHz, the pixel and address widths, and a saturating counter helper.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } rx_state_e;

  localparam int RST_CYC      = 10000; // 50 us low = reset code
  localparam int TH_CYC       = 120;   // 600 ns: 1/0 decision threshold
  localparam int MIN_CYC      = 20;    // 100 ns: shorter highs are glitches
  localparam int MAX_HIGH_CYC = 400;   // 2 us: longer highs are errors

  localparam int PIXEL_W    = 24;
  localparam int ADDR_W     = 6;
  localparam int CNT_W      = 16;
  localparam int MAX_PIXELS = 64;

  // Increment a cycle counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/edge2en.sv
// edge2en: one-cycle enable on the rising edge of a synchronous level.
// Ports: clk_i clock, rst_ni async active-low reset, level_i synchronous
//        level, en_o = level_i & ~(level_i delayed by one clock).
module edge2en (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic en_o
);

  logic level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) level_q <= 1'b0;
    else         level_q <= level_i;
  end

  assign en_o = level_i & ~level_q;

endmodule

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: two-flop synchronizer for the asynchronous data line.
// Ports: clk_i clock, rst_ni async active-low clear, d_i async input,
//        q_o synchronized output (cleared to 0 in reset).
module ws2812_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver. Measures each high pulse, decodes
// it as a 0/1 bit, packs 24 bits MSB-first into a GRB pixel with its index in
// the frame, and flags the end of frame on a long low (reset code).
// Ports:
//   clk_in, rst_n_in   clock, async active-low reset
//   din_in             WS2812 data line (asynchronous)
//   pixel_valid_out    1-cycle pulse, pixel_data_out/pixel_idx_out valid
//   pixel_data_out     24-bit pixel, first received bit in [23]
//   pixel_idx_out      pixel index in frame, 0..63
//   frame_done_out     1-cycle pulse at reset code after at least one bit
//   pixel_cnt_out      pixels delivered in the finished frame, held
//   err_out            1-cycle pulse on glitch, long high, partial pixel
//                      or pixel overflow
// All outputs are pulses with no back-pressure: the consumer samples
// pixel_* and pixel_cnt_out on the cycle the matching pulse is high.
module ws2812_rx #(
  parameter int MIN_CYC      = ws2812_pkg::MIN_CYC,
  parameter int TH_CYC       = ws2812_pkg::TH_CYC,
  parameter int MAX_HIGH_CYC = ws2812_pkg::MAX_HIGH_CYC,
  parameter int RST_CYC      = ws2812_pkg::RST_CYC
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        din_in,
  output logic        pixel_valid_out,
  output logic [23:0] pixel_data_out,
  output logic [5:0]  pixel_idx_out,
  output logic        frame_done_out,
  output logic [6:0]  pixel_cnt_out,
  output logic        err_out
);
  import ws2812_pkg::*;

  localparam logic [15:0] MIN_C  = 16'(MIN_CYC);
  localparam logic [15:0] TH_C   = 16'(TH_CYC);
  localparam logic [15:0] MAX_C  = 16'(MAX_HIGH_CYC);
  localparam logic [15:0] RST_C1 = 16'(RST_CYC - 1);
  localparam logic [6:0]  NPIX   = 7'(MAX_PIXELS);

  logic din_s, din_s_n, rise, fall;

  ws2812_rx_sync u_sync (.clk_i(clk_in), .rst_ni(rst_n_in), .d_i(din_in), .q_o(din_s));

  assign din_s_n = ~din_s;
  edge2en u_rise (.clk_i(clk_in), .rst_ni(rst_n_in), .level_i(din_s),   .en_o(rise));
  edge2en u_fall (.clk_i(clk_in), .rst_ni(rst_n_in), .level_i(din_s_n), .en_o(fall));

  rx_state_e   state_q, state_d;
  logic [15:0] high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  pix_idx_q, pix_idx_d;     // 0..64, 64 means frame is full
  logic [23:0] shift_q, shift_d;
  logic        ovf_q, ovf_d;             // overflow already reported this frame
  logic        pixel_valid_q, pixel_valid_d;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic [5:0]  pixel_idx_q, pixel_idx_d;
  logic        frame_done_q, frame_done_d;
  logic [6:0]  pixel_cnt_q, pixel_cnt_d;
  logic        err_q, err_d;
  logic        bit_v;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_SYNC;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      pix_idx_q     <= '0;
      shift_q       <= '0;
      ovf_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_idx_q   <= '0;
      frame_done_q  <= 1'b0;
      pixel_cnt_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_idx_q     <= pix_idx_d;
      shift_q       <= shift_d;
      ovf_q         <= ovf_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_idx_q   <= pixel_idx_d;
      frame_done_q  <= frame_done_d;
      pixel_cnt_q   <= pixel_cnt_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    pix_idx_d     = pix_idx_q;
    shift_d       = shift_q;
    ovf_d         = ovf_q;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_idx_d   = pixel_idx_q;
    frame_done_d  = 1'b0;
    pixel_cnt_d   = pixel_cnt_q;
    err_d         = 1'b0;
    bit_v         = (high_cnt_q >= TH_C);

    case (state_q)
      // Wait for a full reset-code low before trusting the line.
      ST_SYNC: begin
        if (din_s) begin
          low_cnt_d = '0;
        end else if (low_cnt_q >= RST_C1) begin
          state_d = ST_IDLE;
        end else begin
          low_cnt_d = sat_inc(low_cnt_q);
        end
      end
      ST_IDLE: begin
        bit_cnt_d = '0;
        pix_idx_d = '0;
        ovf_d     = 1'b0;
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = 16'd1;
        end
      end
      ST_HIGH: begin
        high_cnt_d = sat_inc(high_cnt_q);
        // The long-high check wins over a fall in the same cycle.
        if (high_cnt_q >= MAX_C) begin
          err_d     = 1'b1;
          state_d   = ST_SYNC;
          low_cnt_d = '0;
        end else if (fall) begin
          if (high_cnt_q < MIN_C) begin
            err_d     = 1'b1;
            state_d   = ST_SYNC;
            low_cnt_d = '0;
          end else begin
            shift_d   = {shift_q[22:0], bit_v};
            state_d   = ST_LOW;
            low_cnt_d = 16'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              if (pix_idx_q < NPIX) begin
                pixel_valid_d = 1'b1;
                pixel_data_d  = {shift_q[22:0], bit_v};
                pixel_idx_d   = pix_idx_q[5:0];
                pix_idx_d     = pix_idx_q + 7'd1;
              end else if (!ovf_q) begin
                err_d = 1'b1;
                ovf_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d    = ST_HIGH;
          high_cnt_d = 16'd1;
        end else if (low_cnt_q >= RST_C1) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          pixel_cnt_d  = pix_idx_q;
          if (bit_cnt_q != 5'd0) err_d = 1'b1;  // partial pixel dropped
          bit_cnt_d    = '0;
        end else begin
          low_cnt_d = sat_inc(low_cnt_q);
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign pixel_valid_out = pixel_valid_q;
  assign pixel_data_out  = pixel_data_q;
  assign pixel_idx_out   = pixel_idx_q;
  assign frame_done_out  = frame_done_q;
  assign pixel_cnt_out   = pixel_cnt_q;
  assign err_out         = err_q;

endmodule
